// File: rtl/corescore_arb_pkg.sv
// Shared types for the corescore stream arbiter: FSM state encoding and
// the grant-index width helper used to size port-index buses.
package corescore_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Grant-index width; a single port still needs one bit to carry an index.
  function automatic int grant_width(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/corescore_rr_pick.sv
// Round-robin picker: finds the first set request searching upward from
// (last_idx + 1) mod NUM_PORTS, wrapping around.
module corescore_rr_pick
  import corescore_arb_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  localparam int GW        = grant_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [GW-1:0]        last_idx,
  output logic                 found,
  output logic [GW-1:0]        next_idx
);

  // Scan offsets 1..NUM_PORTS from last_idx; the earliest hit wins.
  always_comb begin
    found    = 1'b0;
    next_idx = last_idx;
    for (int i = 0; i < NUM_PORTS; i++) begin
      logic [GW:0] cand_s;
      cand_s = {1'b0, last_idx} + (GW+1)'(1) + (GW+1)'(i);
      if (cand_s >= (GW+1)'(NUM_PORTS)) begin
        cand_s = cand_s - (GW+1)'(NUM_PORTS);
      end else begin
        cand_s = cand_s;
      end
      if (!found && req[cand_s[GW-1:0]]) begin
        found    = 1'b1;
        next_idx = cand_s[GW-1:0];
      end else begin
        found    = found;
        next_idx = next_idx;
      end
    end
  end

endmodule

// File: rtl/corescore_stream_arbiter_chk.sv
// Protocol checker for the stream arbiter outputs: ready exclusivity,
// output stability under backpressure and grant stability while busy.
module corescore_stream_arbiter_chk
  import corescore_arb_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  localparam int GW        = grant_width(NUM_PORTS)
) (
  input logic                 i_clk,
  input logic                 i_rst,
  input logic [NUM_PORTS-1:0] o_tready,
  input logic [7:0]           o_tdata,
  input logic                 o_tlast,
  input logic                 o_tvalid,
  input logic                 i_tready,
  input logic [GW-1:0]        o_grant,
  input logic                 o_busy
);

  a_ready_onehot0: assert property (@(posedge i_clk) disable iff (i_rst)
    $onehot0(o_tready));

  a_ready_idle_zero: assert property (@(posedge i_clk) disable iff (i_rst)
    !o_busy |-> (o_tready == {NUM_PORTS{1'b0}}));

  a_hold_on_stall: assert property (@(posedge i_clk) disable iff (i_rst)
    (o_tvalid && !i_tready) |=> (o_tvalid && $stable(o_tdata) && $stable(o_tlast)));

  a_grant_stable: assert property (@(posedge i_clk) disable iff (i_rst)
    o_busy |=> $stable(o_grant));

endmodule

// File: rtl/corescore_stream_arbiter.sv
// Merges NUM_PORTS byte streams into one, granting whole messages in
// round-robin order behind a single output register.
module corescore_stream_arbiter
  import corescore_arb_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  localparam int GW        = grant_width(NUM_PORTS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [8*NUM_PORTS-1:0] i_tdata,
  input  logic [NUM_PORTS-1:0]   i_tlast,
  input  logic [NUM_PORTS-1:0]   i_tvalid,
  output logic [NUM_PORTS-1:0]   o_tready,
  output logic [7:0]             o_tdata,
  output logic                   o_tlast,
  output logic                   o_tvalid,
  input  logic                   i_tready,
  output logic [GW-1:0]          o_grant,
  output logic                   o_busy
);

  arb_state_e           state_r;
  logic [GW-1:0]        grant_r;
  logic [GW-1:0]        last_grant_r;
  logic [7:0]           data_r;
  logic                 last_r;
  logic                 valid_r;
  logic                 busy_r;

  logic                 pick_found_s;
  logic [GW-1:0]        pick_idx_s;
  logic                 slot_free_s;
  logic                 sel_valid_s;
  logic [7:0]           sel_data_s;
  logic                 sel_last_s;
  logic                 load_s;
  logic [NUM_PORTS-1:0] tready_s;

  corescore_rr_pick #(
    .NUM_PORTS (NUM_PORTS)
  ) u_pick (
    .req      (i_tvalid),
    .last_idx (last_grant_r),
    .found    (pick_found_s),
    .next_idx (pick_idx_s)
  );

  assign slot_free_s = !valid_r || i_tready;
  assign sel_valid_s = i_tvalid[grant_r];
  assign sel_data_s  = i_tdata[{grant_r, 3'b000} +: 8];
  assign sel_last_s  = i_tlast[grant_r];

  // Only the granted port sees ready, and only while the output slot can take a beat.
  always_comb begin
    tready_s = {NUM_PORTS{1'b0}};
    load_s   = 1'b0;
    if (state_r == ST_BUSY) begin
      tready_s[grant_r] = slot_free_s;
      load_s            = sel_valid_s && slot_free_s;
    end else begin
      tready_s = {NUM_PORTS{1'b0}};
      load_s   = 1'b0;
    end
  end

  // Arbitration FSM and output register; reset discards any in-flight beat.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r      <= ST_IDLE;
      grant_r      <= {GW{1'b0}};
      last_grant_r <= GW'(NUM_PORTS - 1);
      data_r       <= 8'h00;
      last_r       <= 1'b0;
      valid_r      <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      if (load_s) begin
        data_r  <= sel_data_s;
        last_r  <= sel_last_s;
        valid_r <= 1'b1;
      end else if (valid_r && i_tready) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end

      case (state_r)
        ST_IDLE: begin
          if (pick_found_s) begin
            state_r <= ST_BUSY;
            grant_r <= pick_idx_s;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (load_s && sel_last_s) begin
            state_r      <= ST_IDLE;
            last_grant_r <= grant_r;
            busy_r       <= 1'b0;
          end else begin
            state_r <= ST_BUSY;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign o_tready = tready_s;
  assign o_tdata  = data_r;
  assign o_tlast  = last_r;
  assign o_tvalid = valid_r;
  assign o_grant  = grant_r;
  assign o_busy   = busy_r;

endmodule
